// File: rtl/regfile_pkg.sv
// Shared sizing constants for the integer register file and its writeback path.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr, and ptr moves past the winner on advance.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // advance is only meaningful when a grant was actually taken this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: arbitrates producers onto the single register-file write port
// and tracks pending destinations so issue can detect RAW/WAW hazards.
module regfile_wb_sched #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = regfile_pkg::XLEN,
  parameter int REG_AW  = regfile_pkg::REG_AW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][REG_AW-1:0]   req_rd,
  input  logic [NUM_REQ-1:0][XLEN-1:0]     req_data,
  output logic                             wb_we,
  output logic [REG_AW-1:0]                wb_rd,
  output logic [XLEN-1:0]                  wb_data,
  input  logic                             issue_valid,
  input  logic [REG_AW-1:0]                issue_rd,
  output logic                             issue_ready,
  input  logic [REG_AW-1:0]                rs1,
  input  logic [REG_AW-1:0]                rs2,
  output logic                             rs1_busy,
  output logic                             rs2_busy,
  output logic [regfile_pkg::NUM_REGS-1:0] busy_mask
);

  import regfile_pkg::*;

  logic [NUM_REQ-1:0]  grant;
  logic                handshake;
  logic [REG_AW-1:0]   sel_rd;
  logic [XLEN-1:0]     sel_data;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                alloc;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (handshake),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign handshake = |(req_valid & grant);

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[i];
        sel_data = req_data[i];
      end
    end
  end

  // The register file never stalls, so every accepted request lands here for one cycle;
  // writes to x0 still consume the turn but never assert the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (handshake) begin
      wb_we   <= (sel_rd != '0);
      wb_rd   <= sel_rd;
      wb_data <= sel_data;
    end else begin
      wb_we   <= 1'b0;
    end
  end

  assign issue_ready = ~busy[issue_rd];
  assign alloc       = issue_valid && issue_ready && (issue_rd != '0);

  // Clear is applied before set so a same-cycle allocation of the committing register stays busy.
  always_comb begin
    busy_next = busy;
    if (wb_we) begin
      busy_next[wb_rd] = 1'b0;
    end
    if (alloc) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign rs1_busy  = busy[rs1];
  assign rs2_busy  = busy[rs2];
  assign busy_mask = busy;

endmodule
